lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum cycles to wait for mem_ack before aborting an access.
REQ-002 Parameter RIDX_W, default 6, width of destination-register index.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 op_valid  in  1  execute stage presents a memory op this cycle.
REQ-006 op_ready  out  1  unit idle and able to accept an op.
REQ-007 op_load  in  1  1 = load, 0 = store; sampled with op_valid.
REQ-008 op_addr  in  32  word address (memory indexed by word, not byte).
REQ-009 op_wdata  in  32  store data.
REQ-010 op_rd  in  RIDX_W  load destination register index.
REQ-011 mem_req  out  1  access request to data memory, held until mem_ack.
REQ-012 mem_write  out  1  1 = write access; valid while mem_req.
REQ-013 mem_addr  out  32  latched address; valid while mem_req.
REQ-014 mem_wdata  out  32  latched store data; valid while mem_req.
REQ-015 mem_rdata  in  32  read data, valid in mem_ack cycle.
REQ-016 mem_ack  in  1  single-cycle completion strobe from memory.
REQ-017 wb_valid  out  1  one-cycle pulse: load data ready for writeback.
REQ-018 wb_data  out  32  loaded word.
REQ-019 wb_rd  out  RIDX_W  destination index of loaded word.
REQ-020 st_done  out  1  one-cycle pulse: store acknowledged.
REQ-021 err  out  1  sticky: an access timed out.

Function
REQ-022 FSM states IDLE, ISSUE, RESP; IDLE is the reset state.
REQ-023 op_ready SHALL be 1 exactly when state is IDLE; op_valid outside IDLE is ignored, no queueing.
REQ-024 IDLE with op_valid: latch op_load/addr/wdata/rd, clear timeout counter, go ISSUE next cycle.
REQ-025 ISSUE: mem_req=1, mem_write=~latched op_load, mem_addr/mem_wdata stable, every cycle until exit.
REQ-026 ISSUE with mem_ack: load -> capture mem_rdata into wb_data, go RESP; store -> st_done=1 next cycle, go IDLE.
REQ-027 RESP: wb_valid=1 for exactly one cycle with wb_data, wb_rd; then IDLE.
REQ-028 Latency: store op accepted cycle N -> mem_req from N+1; ack at cycle M -> st_done at M+1. Load ack at M -> wb_valid at M+1. Minimum op-to-op spacing 3 cycles (load) / 2 (store).
REQ-029 Timeout counter 5-bit saturating, increments each ISSUE cycle without ack; on reaching TIMEOUT without ack: set err, drop mem_req, no wb_valid/st_done, go IDLE.
REQ-030 mem_ack in the same cycle the counter reaches TIMEOUT SHALL win: access completes normally, err unchanged.
REQ-031 mem_ack outside ISSUE SHALL be ignored (no state change, no pulses).
REQ-032 err stays 1 until reset; unit continues accepting ops after a timeout.
REQ-033 wb_data/wb_rd hold last load value between pulses; st_done and wb_valid never high together.

Reset
REQ-034 resetn low at posedge: state IDLE, mem_req/wb_valid/st_done/err=0, op_ready=1, latched regs and wb_data/wb_rd=0, counter=0.
REQ-035 Reset mid-access aborts with no completion pulse; a later stale mem_ack is ignored per REQ-031.

Structure
REQ-036 Shared package holds state enum (IDLE, ISSUE, RESP) and default TIMEOUT constant.
REQ-037 Single module; no sub-module, counter and FSM inline.

Verification
REQ-038 Store addr 5, data 0x1234, ack 2 cycles after mem_req rises -> mem_write=1, mem_addr=5, mem_wdata=0x1234 held, st_done one cycle after ack, err=0.
REQ-039 Load addr 2, rd=7, memory returns 30 on ack -> wb_valid one cycle, wb_data=30, wb_rd=7, op_ready back next cycle.
REQ-040 Load with no ack -> mem_req high exactly 16 cycles, then err=1, no wb_valid; following store addr 0 completes normally.
REQ-041 op_valid held high during ISSUE with different addr -> ignored; mem_addr stays original.
REQ-042 resetn low in ISSUE, then mem_ack pulse after release -> mem_req=0, no st_done/wb_valid, state IDLE.
REQ-043 Ack in the 16th ISSUE cycle -> normal completion, err=0.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared state encoding and defaults for the load/store unit
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } lsu_state_e;

  localparam int LSU_TIMEOUT_DEFAULT = 16;
  localparam int LSU_CNT_W           = 5;

endpackage

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller with ack timeout
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT,
  parameter int RIDX_W  = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_load,
  input  logic [31:0]       op_addr,
  input  logic [31:0]       op_wdata,
  input  logic [RIDX_W-1:0] op_rd,
  output logic              mem_req,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [RIDX_W-1:0] wb_rd,
  output logic              st_done,
  output logic              err
);

  localparam logic [LSU_CNT_W-1:0] TO_LIM = LSU_CNT_W'(TIMEOUT);

  lsu_state_e           state;
  logic                 lat_load;
  logic [RIDX_W-1:0]    lat_rd;
  logic [LSU_CNT_W-1:0] cnt;
  logic [LSU_CNT_W-1:0] cnt_next;

  // Saturating so a large TIMEOUT can never wrap the counter back to zero.
  assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      op_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_load  <= 1'b0;
      lat_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      st_done   <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      wb_valid <= 1'b0;
      st_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            lat_load  <= op_load;
            lat_rd    <= op_rd;
            mem_addr  <= op_addr;
            mem_wdata <= op_wdata;
            mem_write <= ~op_load;
            mem_req   <= 1'b1;
            op_ready  <= 1'b0;
            cnt       <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // An ack arriving in the final allowed cycle beats the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (lat_load) begin
              wb_data  <= mem_rdata;
              wb_rd    <= lat_rd;
              wb_valid <= 1'b1;
              state    <= S_RESP;
            end else begin
              st_done  <= 1'b1;
              op_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end else if (cnt_next >= TO_LIM) begin
            err      <= 1'b1;
            mem_req  <= 1'b0;
            op_ready <= 1'b1;
            cnt      <= cnt_next;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt_next;
          end
        end
        S_RESP: begin
          op_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          mem_req  <= 1'b0;
          op_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
